spi_hex_target: RTL and testbench
=================================

# spi_hex_target

SPI responder (target) that sits in the FPGA top level, on the far end of the SoC's SPI controller pins (clock, MOSI, MISO, chip select). It exposes eight 7-bit segment registers that drive the board's HEX0..HEX7 displays. Software can write and read back these registers over SPI, so the displays are no longer tied off. All SPI inputs are oversampled in the system clock domain; there is no logic clocked by the SPI clock.

## Interface
- `N_DIGITS`, 8: number of segment registers and digits. Fixed at 8; the address field is 3 bits.
- `SEG_RESET`, 7'h7f: reset value of each segment register. Segments are active-low, so this means all segments off.

- `clk`, in, 1: system clock. Its frequency must be at least 8× the `spi_sck` frequency.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `spi_sck`, in, 1: SPI clock, mode 0 (CPOL=0, CPHA=0). Asynchronous to `clk`.
- `spi_mosi`, in, 1: controller-to-target data, MSB first.
- `spi_cs_n`, in, 1: chip select, active low.
- `spi_miso`, out, 1: target-to-controller data. Driven 0 when not selected.
- `hex_seg`, out, 56: segment patterns. Bits [7k+6:7k] drive HEXk.
- `wr_strobe`, out, 1: one-`clk` pulse whenever a segment register is written.
- `wr_addr`, out, 3: address of the most recent write. Holds its value between writes.

## Operation
- **Synchronisers.** `spi_sck`, `spi_mosi` and `spi_cs_n` each pass through a 2-flop synchroniser. A third flop on SCK provides rise/fall edge detection.
- **Frame format.** One command byte, then one or more data bytes.
  - Command bit 7 = R/nW (1 = read).
  - Command bits [6:3] must be 0.
  - Command bits [2:0] = start address.
- **FSM states:**
  - IDLE: CS high.
  - CMD: shifting in the command byte.
  - DATA: shifting data bytes.
  - IGNORE: invalid command; the rest of the frame is discarded.
- **Transitions:**
  - IDLE→CMD when synchronised CS falls.
  - CMD→DATA on the 8th SCK rise if bits [6:3]==0; otherwise CMD→IGNORE.
  - Any state→IDLE when synchronised CS rises.
- **3-bit bit counter.** Counts SCK rises within a byte and wraps 7→0. It is cleared on entry to CMD.
- **MOSI sampling.** MOSI is sampled on detected SCK rises. `spi_miso` updates on detected SCK falls.
- **Address pointer.** On the 8th rise of the command byte, the pointer is loaded from bits [2:0] and the tx shift register is loaded with {1'b0, reg[ptr]}.
- **Write (R/nW=0).** On the 8th rise of each data byte:
  - reg[ptr] <= data[6:0]; data bit 7 is ignored.
  - `wr_strobe` pulses and `wr_addr` <= ptr.
  - ptr increments, wrapping 7→0.
- **Read (R/nW=1).** On each SCK fall, `spi_miso` <= tx[7] and tx shifts left.
  - On the 8th rise of each data byte, ptr increments (wrapping 7→0) and tx is reloaded from the new reg[ptr].
  - Reads never modify registers.
- **MISO during CMD and IGNORE.** `spi_miso` is 0, and it is forced to 0 in IDLE.
- **Abort.** If CS rises mid-byte, the partial byte is discarded and no write occurs. Bytes already completed are kept.
- **Reset.** Asserting `reset_n` mid-frame returns the block to IDLE immediately. All registers take their reset values.
- **Reset values:**
  - `hex_seg` = {8{SEG_RESET}}, i.e. all ones.
  - `spi_miso` = 0, `wr_strobe` = 0, `wr_addr` = 0.
  - FSM = IDLE.

## Timing
- An SPI pin change is detected internally on the 3rd `clk` edge after the pin changes (2 synchroniser flops + 1 edge flop).
- **Write latency.** `hex_seg` and `wr_strobe` update on the `clk` edge after the 8th data-bit rise is detected, i.e. ≤4 `clk` cycles after the SCK edge.
- **MISO latency.** `spi_miso` is valid ≤4 `clk` cycles after an SCK fall.
  - With `clk` ≥ 8× SCK, the SCK half-period is ≥4 `clk` cycles, so MISO is stable before the next SCK rise.
- **First read bit.** The first read data bit (bit 7) appears after the SCK fall that follows the 8th command rise.
- **Simultaneous events.** If CS rise and an SCK edge are detected in the same `clk` cycle, CS wins: no write, and the FSM goes to IDLE.
- **Frame spacing.** There is no minimum gap between frames beyond one synchronised CS-high sample.

## Test plan
- **Reset.** Apply `reset_n`=0 → `hex_seg`=56'hFF_FFFF_FFFF_FFFF, `spi_miso`=0, `wr_strobe`=0. Repeat by asserting reset in the middle of a write frame (0x02, 0x40): registers return to 7'h7f and no `wr_strobe` occurs.
- **Single write.** Send frame 0x02, 0x40 with SCK = `clk`/8 → `hex_seg`[20:14]=7'h40, exactly one `wr_strobe` pulse with `wr_addr`=2, all other digits stay at 7'h7f.
- **Read-back.** After the single write, send frame 0x82, 0x00 → the MISO byte captured on SCK rises is 0x40. MISO is 0 during the command byte.
- **Burst write with wrap.** Send 0x07, 0x11, 0x22, 0x33 → reg7=0x11, reg0=0x22, reg1=0x33. Three strobes occur with `wr_addr` = 7, 0, 1. A following burst read 0x87 returns 0x11, 0x22, 0x33.
- **Abort.** Raise CS after 12 bits of frame 0x03, 0x5A → reg3 is unchanged and no strobe occurs. The next full frame works normally.
- **Invalid command.** Send frame 0x48, 0x00 (reserved bit set) → no register changes, `spi_miso`=0 for the whole frame.

Source files
------------

// File: rtl/spi_hex_target.sv
// SPI mode-0 target holding eight 7-bit segment registers for HEX0..HEX7.
// SPI pins are oversampled in the clk domain; there is no logic clocked by SCK.
module spi_hex_target #(
    parameter int N_DIGITS = 8,
    parameter logic [6:0] SEG_RESET = 7'h7f
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    output logic [7*N_DIGITS-1:0] hex_seg,
    output logic                  wr_strobe,
    output logic [2:0]            wr_addr,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, IGNORE = 2'd3} state_t;

    state_t state, state_next;

    logic       sck_s1, sck_s2, sck_s3;
    logic       mosi_s1, mosi_s2;
    logic       cs_s1, cs_s2;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] tx;
    logic [2:0] ptr;
    logic [2:0] ptr_inc;
    logic       is_read;
    logic [6:0] segs [N_DIGITS];

    logic       sck_rise, sck_fall, byte_done;
    logic [7:0] rx_byte;

    assign sck_rise  = sck_s2 & ~sck_s3;
    assign sck_fall  = ~sck_s2 & sck_s3;
    // Byte including the bit being sampled on this rise.
    assign rx_byte   = {shift_in, mosi_s2};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && !cs_s2;
    assign ptr_inc   = ptr + 3'd1;
    assign fsm_state = state;

    always_comb begin
        for (int k = 0; k < N_DIGITS; k++) begin
            hex_seg[7*k +: 7] = segs[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A CS-high sample always wins over any SCK edge seen in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!cs_s2) state_next = CMD;
            CMD: begin
                if (cs_s2) state_next = IDLE;
                else if (byte_done) state_next = (rx_byte[6:3] == 4'd0) ? DATA : IGNORE;
            end
            DATA:    if (cs_s2) state_next = IDLE;
            IGNORE:  if (cs_s2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            tx        <= 8'd0;
            ptr       <= 3'd0;
            is_read   <= 1'b0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 3'd0;
            for (int k = 0; k < N_DIGITS; k++) segs[k] <= SEG_RESET;
        end else begin
            wr_strobe <= 1'b0;
            if (state == IDLE || cs_s2) begin
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b0;
            end else begin
                if (sck_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                case (state)
                    CMD: begin
                        spi_miso <= 1'b0;
                        if (byte_done) begin
                            ptr     <= rx_byte[2:0];
                            is_read <= rx_byte[7];
                            tx      <= {1'b0, segs[rx_byte[2:0]]};
                        end
                    end
                    DATA: begin
                        if (is_read) begin
                            if (sck_fall) begin
                                spi_miso <= tx[7];
                                tx       <= {tx[6:0], 1'b0};
                            end
                            if (byte_done) begin
                                ptr <= ptr_inc;
                                tx  <= {1'b0, segs[ptr_inc]};
                            end
                        end else if (byte_done) begin
                            segs[ptr] <= rx_byte[6:0];
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            ptr       <= ptr_inc;
                        end
                    end
                    default: spi_miso <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_hex_target.sv
// Bench for spi_hex_target: drives SPI frames at SCK = clk/8 and checks writes,
// read-back bytes and register contents against a frame-level model.
module tb_spi_hex_target;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_miso;
    logic [55:0] hex_seg;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [1:0]  fsm_state;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] got_rd_q[$];
    logic [7:0] frame_b[$];
    bit         chk_b[$];
    logic [6:0] model_regs [8];

    logic [9:0] mon_e;
    logic [7:0] mon_g, mon_r;

    spi_hex_target dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .hex_seg   (hex_seg),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [55:0] model_vec();
        logic [55:0] v;
        for (int k = 0; k < 8; k++) v[7*k +: 7] = model_regs[k];
        return v;
    endfunction

    // Monitor: pops expected writes on each strobe and expected MISO bytes as captured.
    always @(negedge clk) begin
        if (reset_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got addr %0d expected no write", wr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {wr_addr, hex_seg[wr_addr*7 +: 7]}, mon_e);
            end
        end
        if (got_rd_q.size() > 0) begin
            mon_g = got_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_miso_byte: got %0h expected none", mon_g);
            end else begin
                mon_r = exp_rd_q.pop_front();
                check("miso_byte", mon_g, mon_r);
            end
        end
    end

    // Model the frame in frame_b, then drive n_bits of it; optionally reset before CS rises.
    task automatic run_frame(input int n_bits, input bit rst_abort);
        int         n_full;
        logic [7:0] cmd, b, rx;
        logic [2:0] addr;
        bit         valid;
        n_full = n_bits / 8;
        chk_b.delete();
        cmd   = frame_b[0];
        valid = (cmd[6:3] == 4'd0);
        addr  = cmd[2:0];
        for (int i = 0; i < n_full; i++) begin
            if (i == 0 || !valid) begin
                exp_rd_q.push_back(8'h00);
                chk_b.push_back(1'b1);
            end else if (cmd[7]) begin
                exp_rd_q.push_back({1'b0, model_regs[addr]});
                chk_b.push_back(1'b1);
                addr = addr + 3'd1;
            end else begin
                model_regs[addr] = frame_b[i][6:0];
                exp_q.push_back({addr, frame_b[i][6:0]});
                chk_b.push_back(1'b0);
                addr = addr + 3'd1;
            end
        end

        @(negedge clk);
        spi_cs_n = 1'b0;
        rx = 8'h00;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n_bits; k++) begin
            b = frame_b[k / 8];
            spi_mosi = b[7 - (k % 8)];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sck = 1'b1;
            if ((k % 8) == 7 && chk_b[k / 8]) got_rd_q.push_back(rx);
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (rst_abort) begin
            reset_n = 1'b0;
            for (int k = 0; k < 8; k++) model_regs[k] = 7'h7f;
            repeat (2) @(negedge clk);
        end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        reset_n  = 1'b1;
        repeat (6) @(negedge clk);
        check("hex_seg", hex_seg, model_vec());
        check("pending_writes", exp_q.size(), 0);
        check("pending_reads", exp_rd_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int n_bytes, n_bits;
        logic [7:0] c;
        for (int k = 0; k < 8; k++) model_regs[k] = 7'h7f;

        repeat (3) @(negedge clk);
        check("reset_hex_seg", hex_seg, 56'hFF_FFFF_FFFF_FFFF);
        check("reset_miso", spi_miso, 1'b0);
        check("reset_wr_strobe", wr_strobe, 1'b0);
        check("reset_wr_addr", wr_addr, 3'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        frame_b = '{8'h02, 8'h40};
        run_frame(16, 1'b0);
        check("single_write_hex2", hex_seg[20:14], 7'h40);
        check("single_write_hex3", hex_seg[27:21], 7'h7f);

        frame_b = '{8'h82, 8'h00};
        run_frame(16, 1'b0);

        frame_b = '{8'h07, 8'h11, 8'h22, 8'h33};
        run_frame(32, 1'b0);
        check("burst_hex7", hex_seg[55:49], 7'h11);
        check("burst_hex0", hex_seg[6:0], 7'h22);
        check("burst_hex1", hex_seg[13:7], 7'h33);
        frame_b = '{8'h87, 8'h00, 8'h00, 8'h00};
        run_frame(32, 1'b0);

        frame_b = '{8'h03, 8'h5A};
        run_frame(12, 1'b0);
        check("abort_hex3", hex_seg[27:21], 7'h7f);
        run_frame(16, 1'b0);
        check("after_abort_hex3", hex_seg[27:21], 7'h5a);

        frame_b = '{8'h48, 8'h00};
        run_frame(16, 1'b0);

        frame_b = '{8'h05, 8'h2A};
        run_frame(16, 1'b0);
        frame_b = '{8'h02, 8'h40};
        run_frame(12, 1'b1);
        check("reset_midframe_hex_seg", hex_seg, 56'hFF_FFFF_FFFF_FFFF);
        check("reset_midframe_miso", spi_miso, 1'b0);

        for (int f = 0; f < 30; f++) begin
            n_bytes = $urandom_range(1, 4);
            c = 8'h00;
            c[7] = 1'($urandom_range(0, 1));
            c[2:0] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) c[6:3] = 4'($urandom_range(1, 15));
            frame_b.delete();
            frame_b.push_back(c);
            for (int i = 1; i < n_bytes; i++) frame_b.push_back(8'($urandom_range(0, 255)));
            n_bits = n_bytes * 8;
            if ($urandom_range(0, 4) == 0) n_bits = $urandom_range(1, n_bytes * 8 - 1);
            run_frame(n_bits, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
